// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequenced multiplier: register/ALU widths,
// the ALU opcodes it drives, and its controller state encoding.
package alu_mul_seq_pkg;

    localparam int RegWidth       = 16;
    localparam int AluOpWidth     = 4;
    localparam int MSeqStateWidth = 2;

    localparam logic [AluOpWidth-1:0] ALU_OP_ADD = 4'h0;
    localparam logic [AluOpWidth-1:0] ALU_OP_LSL = 4'h6;

    typedef enum logic [MSeqStateWidth-1:0] {
        MSEQ_IDLE = 2'd0,
        MSEQ_ADD  = 2'd1,
        MSEQ_SHL  = 2'd2,
        MSEQ_DONE = 2'd3
    } mseq_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier with no datapath of its own: every add
// and every shift is borrowed from the shared ALU through a req/gnt pair.
// Each multiplier bit costs one ADD step and one SHL step; a withheld grant
// freezes the controller for that cycle.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int W = RegWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          result,
    output logic                  alu_req,
    input  logic                  alu_gnt,
    output logic [AluOpWidth-1:0] alu_op,
    output logic [W-1:0]          alu_rs,
    output logic [W-1:0]          alu_rt,
    input  logic [W-1:0]          alu_rd
);

    mseq_state_e  state;
    logic [W-1:0] product;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;

    // Controller: operand capture, ALU write-back, and the registered
    // busy/done/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MSEQ_IDLE;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MSEQ_IDLE: begin
                    if (start) begin
                        product <= '0;
                        mcand   <= a;
                        mplier  <= b;
                        busy    <= 1'b1;
                        // A zero multiplier skips the ALU entirely.
                        if (b == '0) begin
                            state  <= MSEQ_DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            state <= MSEQ_ADD;
                        end
                    end
                end
                MSEQ_ADD: begin
                    if (alu_gnt) begin
                        // The sum is always requested; it is kept only when
                        // the current multiplier bit is set.
                        if (mplier[0]) product <= alu_rd;
                        state <= MSEQ_SHL;
                    end
                end
                MSEQ_SHL: begin
                    if (alu_gnt) begin
                        mcand  <= alu_rd;
                        mplier <= mplier >> 1;
                        // Stop once no set multiplier bits remain; product is
                        // final here since SHL never touches it.
                        if (mplier[W-1:1] == '0) begin
                            state  <= MSEQ_DONE;
                            done   <= 1'b1;
                            result <= product;
                        end else begin
                            state <= MSEQ_ADD;
                        end
                    end
                end
                MSEQ_DONE: begin
                    state <= MSEQ_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= MSEQ_IDLE;
            endcase
        end
    end

    // ALU drive decoded from state; parked at ADD 0,0 whenever not borrowing.
    always_comb begin
        alu_req = 1'b0;
        alu_op  = ALU_OP_ADD;
        alu_rs  = '0;
        alu_rt  = '0;
        case (state)
            MSEQ_ADD: begin
                alu_req = 1'b1;
                alu_rs  = product;
                alu_rt  = mcand;
            end
            MSEQ_SHL: begin
                alu_req = 1'b1;
                alu_op  = ALU_OP_LSL;
                alu_rs  = mcand;
                alu_rt  = {{(W-1){1'b0}}, 1'b1};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: table of directed multiplies, hand-written
// multi-cycle sequences (stall, busy start, reset), and random operands with
// random grants checked against plain a*b and a grant-count latency model.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    localparam int W = RegWidth;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [W-1:0]          a = '0;
    logic [W-1:0]          b = '0;
    logic                  busy, done;
    logic [W-1:0]          result;
    logic                  alu_req;
    logic                  alu_gnt = 1'b1;
    logic [AluOpWidth-1:0] alu_op;
    logic [W-1:0]          alu_rs, alu_rt, alu_rd;

    int vectors = 0;
    int miscompares = 0;
    logic req_seen = 1'b0;

    always #5 clk = ~clk;

    // Stand-in for the shared ALU.
    assign alu_rd = (alu_op == ALU_OP_ADD) ? alu_rs + alu_rt :
                    (alu_op == ALU_OP_LSL) ? alu_rs << alu_rt[3:0] : '0;

    alu_mul_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op(alu_op),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_rd(alu_rd)
    );

    always @(negedge clk) if (alu_req) req_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // mode 0: grant always high; 1: random grant; 2: grant low for s_len
    // edges starting after edge s_after (counted from E0).
    task automatic run_mul(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input int mode, input int s_after, input int s_len,
                           output logic [W-1:0] res, output int edges, output int model_edges);
        int n, grants, cnt;
        logic got;
        n = 0;
        for (int i = 0; i < W; i++) if (tb_[i]) n = i + 1;
        grants = 0; cnt = 0; got = 1'b0;
        model_edges = (n == 0) ? 0 : -1;
        a = ta; b = tb_; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
            if (mode == 2 && !alu_gnt) begin
                check({tag, "_stall_op"}, 32'(alu_op), 32'(ALU_OP_LSL));
                check({tag, "_stall_mcand"}, 32'(alu_rs), 32'(ta));
            end
            case (mode)
                1: alu_gnt = ($urandom_range(0, 3) != 0);
                2: alu_gnt = !(cnt >= s_after && cnt < s_after + s_len);
                default: alu_gnt = 1'b1;
            endcase
            @(posedge clk);
            cnt++;
            if (alu_gnt && grants < 2 * n) begin
                grants++;
                if (grants == 2 * n) model_edges = cnt;
            end
            #1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        res = result;
        edges = cnt;
        alu_gnt = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_res;
        int           exp_edges;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] res;
        int edges, medges;
        logic got;
        logic [W-1:0] ra, rb;

        vecs[0] = '{16'd7,    16'd6,    16'd42,    6};
        vecs[1] = '{16'h1234, 16'h0000, 16'h0000,  0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0001,  32};
        vecs[3] = '{16'd300,  16'd300,  16'd24464, 18};
        vecs[4] = '{16'd1,    16'd1,    16'd1,     2};
        vecs[5] = '{16'h8000, 16'd2,    16'h0000,  4};

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_req", 32'(alu_req), 32'd0);
        check("rst_op", 32'(alu_op), 32'(ALU_OP_ADD));
        check("rst_rs", 32'(alu_rs), 32'd0);
        check("rst_rt", 32'(alu_rt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            req_seen = 1'b0;
            run_mul($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, 0, 0, 0, res, edges, medges);
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_latency", i), 32'(edges), 32'(vecs[i].exp_edges));
            if (vecs[i].vb == '0) check("zero_no_req", 32'(req_seen), 32'd0);
        end

        // Grant stall in the first SHL: 3 extra cycles
        run_mul("stall", 16'd5, 16'd3, 2, 1, 3, res, edges, medges);
        check("stall_result", 32'(res), 32'd15);
        check("stall_latency", 32'(edges), 32'd7);

        // Start while busy is dropped; result holds while idle
        a = 16'd7; b = 16'd6; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; a = 16'd9; b = 16'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        check("busy_start_done", 32'(got), 32'd1);
        check("busy_start_result", 32'(result), 32'd42);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_result", k), 32'(result), 32'd42);
            check($sformatf("hold%0d_busy", k), 32'(busy), 32'd0);
        end
        run_mul("after_busy", 16'd9, 16'd9, 0, 0, 0, res, edges, medges);
        check("after_busy_result", 32'(res), 32'd81);

        // Reset mid-operation takes effect without waiting for a clock edge
        a = 16'd100; b = 16'd100; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_req", 32'(alu_req), 32'd0);
        check("midrst_op", 32'(alu_op), 32'(ALU_OP_ADD));
        check("midrst_rs", 32'(alu_rs), 32'd0);
        check("midrst_rt", 32'(alu_rt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_mul("post_rst", 16'd2, 16'd3, 0, 0, 0, res, edges, medges);
        check("post_rst_result", 32'(res), 32'd6);
        check("post_rst_latency", 32'(edges), 32'd4);

        // Random operands with random grant
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = (i < 4) ? W'($urandom_range(0, 15)) : W'($urandom);
            run_mul($sformatf("rnd%0d", i), ra, rb, 1, 0, 0, res, edges, medges);
            check($sformatf("rnd%0d_result", i), 32'(res), 32'(W'(32'(ra) * 32'(rb))));
            check($sformatf("rnd%0d_latency", i), 32'(edges), 32'(medges));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
